// File: rtl/id_exe_pipe_pkg.sv
// Shared widths and field offsets for the ID->EXE pipeline register.
// Also holds the packed layout of the EXE->stall-unit status bus.
package id_exe_pipe_pkg;

  localparam int ID_TO_EXE_BUS_WD = 48;
  localparam int ID_TO_EXE_MEMGEN = 47;
  localparam int ID_TO_EXE_DEST   = 0;
  localparam int EXE_TO_ST_BUS_WD = 7;
  localparam int DEST_W           = 5;

  // Field order matches {EXE_valid, sel_MEM_gene, dest} as the stall unit expects.
  typedef struct packed {
    logic              valid;
    logic              sel_mem_gene;
    logic [DEST_W-1:0] dest;
  } exe_to_st_t;

endpackage

// File: rtl/id_exe_pipe_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Used to count load-use stall cycles for performance debug.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = &r_cnt;

  // NOTE: clocked state uses non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/id_exe_pipe.sv
// ID->EXE pipeline register with valid/allowin handshake, load-use bubble,
// branch-flush kill of the ID instruction, and a saturating stall-cycle counter.
module id_exe_pipe
  import id_exe_pipe_pkg::*;
#(
  parameter int ID_TO_EXE_W = ID_TO_EXE_BUS_WD,
  parameter int MEMGEN_BIT  = ID_TO_EXE_MEMGEN,
  parameter int DEST_LSB    = ID_TO_EXE_DEST,
  parameter int CNT_W       = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ID_valid,
  input  logic [ID_TO_EXE_W-1:0]      ID_to_EXE_bus,
  input  logic [0:0]                  ST_to_ID_bus,
  input  logic                        br_flush,
  input  logic                        EXE_ready_go,
  input  logic                        MEM_allowin,
  output logic                        ID_allowin,
  output logic                        EXE_allowin,
  output logic                        EXE_valid,
  output logic [ID_TO_EXE_W-1:0]      EXE_bus,
  output logic                        EXE_to_MEM_valid,
  output logic [EXE_TO_ST_BUS_WD-1:0] EXE_to_ST_bus,
  output logic [CNT_W-1:0]            stall_cnt
);

  logic                   r_exe_valid;
  logic [ID_TO_EXE_W-1:0] r_exe_bus;
  logic                   w_id_ready_go;
  logic                   w_exe_allowin;
  logic                   w_id_to_exe_valid;
  logic                   w_stall;
  exe_to_st_t             w_st;

  assign w_id_ready_go     = ST_to_ID_bus[0];
  assign w_exe_allowin     = !r_exe_valid || (EXE_ready_go && MEM_allowin);
  // Flush kills the ID instruction, so it never transfers and never counts as a stall.
  assign w_id_to_exe_valid = ID_valid && w_id_ready_go && !br_flush;
  assign w_stall           = ID_valid && !w_id_ready_go && !br_flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_exe_valid <= 1'b0;
      r_exe_bus   <= '0;
    end else if (w_exe_allowin) begin
      r_exe_valid <= w_id_to_exe_valid;
      // Payload only loads on a real transfer; a bubble leaves it stale.
      if (w_id_to_exe_valid) begin
        r_exe_bus <= ID_to_EXE_bus;
      end
    end
  end

  // Status to the stall unit comes from registered state only.
  assign w_st.valid        = r_exe_valid;
  assign w_st.sel_mem_gene = r_exe_bus[MEMGEN_BIT];
  assign w_st.dest         = r_exe_bus[DEST_LSB +: DEST_W];

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .resetn (resetn),
    .i_inc  (w_stall),
    .o_cnt  (stall_cnt)
  );

  assign ID_allowin       = !ID_valid || (w_id_ready_go && w_exe_allowin) || br_flush;
  assign EXE_allowin      = w_exe_allowin;
  assign EXE_valid        = r_exe_valid;
  assign EXE_bus          = r_exe_bus;
  assign EXE_to_MEM_valid = r_exe_valid && EXE_ready_go;
  assign EXE_to_ST_bus    = w_st;

endmodule

// File: tb/tb_id_exe_pipe.sv
// Self-checking bench for id_exe_pipe: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the handshake rules.
module tb_id_exe_pipe;
  import id_exe_pipe_pkg::*;

  localparam int W  = ID_TO_EXE_BUS_WD;
  localparam int MG = ID_TO_EXE_MEMGEN;
  localparam int DL = ID_TO_EXE_DEST;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ID_valid;
  logic [W-1:0]  ID_to_EXE_bus;
  logic [0:0]    ST_to_ID_bus;
  logic          br_flush;
  logic          EXE_ready_go;
  logic          MEM_allowin;

  logic          ID_allowin, EXE_allowin, EXE_valid, EXE_to_MEM_valid;
  logic [W-1:0]  EXE_bus;
  logic [6:0]    EXE_to_ST_bus;
  logic [31:0]   stall_cnt;

  logic          ID_allowin4, EXE_allowin4, EXE_valid4, EXE_to_MEM_valid4;
  logic [W-1:0]  EXE_bus4;
  logic [6:0]    EXE_to_ST_bus4;
  logic [3:0]    stall_cnt4;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit            m_valid;
  logic [W-1:0]  m_bus;
  longint        m_cnt;

  always #5 clk = ~clk;

  id_exe_pipe #(.CNT_W(32)) u_dut (
    .clk(clk), .resetn(resetn), .ID_valid(ID_valid), .ID_to_EXE_bus(ID_to_EXE_bus),
    .ST_to_ID_bus(ST_to_ID_bus), .br_flush(br_flush), .EXE_ready_go(EXE_ready_go),
    .MEM_allowin(MEM_allowin), .ID_allowin(ID_allowin), .EXE_allowin(EXE_allowin),
    .EXE_valid(EXE_valid), .EXE_bus(EXE_bus), .EXE_to_MEM_valid(EXE_to_MEM_valid),
    .EXE_to_ST_bus(EXE_to_ST_bus), .stall_cnt(stall_cnt)
  );

  id_exe_pipe #(.CNT_W(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .ID_valid(ID_valid), .ID_to_EXE_bus(ID_to_EXE_bus),
    .ST_to_ID_bus(ST_to_ID_bus), .br_flush(br_flush), .EXE_ready_go(EXE_ready_go),
    .MEM_allowin(MEM_allowin), .ID_allowin(ID_allowin4), .EXE_allowin(EXE_allowin4),
    .EXE_valid(EXE_valid4), .EXE_bus(EXE_bus4), .EXE_to_MEM_valid(EXE_to_MEM_valid4),
    .EXE_to_ST_bus(EXE_to_ST_bus4), .stall_cnt(stall_cnt4)
  );

  function automatic bit e_exe_allowin();
    return !m_valid || (EXE_ready_go && MEM_allowin);
  endfunction

  function automatic bit e_id_allowin();
    return !ID_valid || (ST_to_ID_bus[0] && e_exe_allowin()) || br_flush;
  endfunction

  function automatic logic [6:0] e_to_st();
    return {m_valid, m_bus[MG], m_bus[DL +: 5]};
  endfunction

  function automatic logic [31:0] e_cnt32();
    return (m_cnt > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_cnt);
  endfunction

  function automatic logic [3:0] e_cnt4();
    return (m_cnt > 15) ? 4'hF : 4'(m_cnt);
  endfunction

  function automatic logic [W-1:0] mk_bus(bit memgen, int dest, logic [31:0] salt);
    logic [W-1:0] b;
    b = W'({salt, salt});
    b[MG] = memgen;
    b[DL +: 5] = 5'(dest);
    return b;
  endfunction

  task automatic drive(bit rn, bit v, logic [W-1:0] b, bit st, bit fl, bit erg, bit ma);
    resetn = rn; ID_valid = v; ID_to_EXE_bus = b; ST_to_ID_bus = st;
    br_flush = fl; EXE_ready_go = erg; MEM_allowin = ma;
    #1;
  endtask

  // Advance one clock edge, updating the model from the inputs presented at that edge.
  task automatic tick();
    bit al, xfer, stall;
    al    = e_exe_allowin();
    xfer  = ID_valid && ST_to_ID_bus[0] && !br_flush;
    stall = ID_valid && !ST_to_ID_bus[0] && !br_flush;
    @(posedge clk);
    if (!resetn) begin
      m_valid = 1'b0; m_bus = '0; m_cnt = 0;
    end else begin
      if (al) begin
        m_valid = xfer;
        if (xfer) m_bus = ID_to_EXE_bus;
      end
      if (stall) m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, mk_bus(1'b1, 9, 32'hDEAD_BEEF), 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (EXE_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", EXE_valid);
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
    end
    checks++;
    if (EXE_to_ST_bus !== 7'h00) begin
      errors++; $display("FAIL reset_st_bus: got %h expected 00", EXE_to_ST_bus);
    end
  endtask

  task automatic test_flow();
    logic [W-1:0] vals [3];
    vals[0] = mk_bus(1'b0, 1, 32'hA0A0_0001);
    vals[1] = mk_bus(1'b0, 2, 32'hB0B0_0002);
    vals[2] = mk_bus(1'b1, 3, 32'hC0C0_0003);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, vals[i], 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      checks++;
      if (EXE_valid !== 1'b1 || EXE_bus !== vals[i]) begin
        errors++;
        $display("FAIL flow_%0d: got valid=%b bus=%h expected valid=1 bus=%h", i, EXE_valid, EXE_bus, vals[i]);
      end
    end
    checks++;
    if (EXE_to_ST_bus !== {1'b1, 1'b1, 5'd3}) begin
      errors++; $display("FAIL flow_st_bus: got %h expected %h", EXE_to_ST_bus, {1'b1, 1'b1, 5'd3});
    end
  endtask

  task automatic test_load_use();
    longint cnt0;
    drive(1'b1, 1'b1, mk_bus(1'b1, 5, 32'h1D00_0005), 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    checks++;
    if (EXE_to_ST_bus !== 7'b1_1_00101) begin
      errors++; $display("FAIL ld_st_bus: got %b expected 1100101", EXE_to_ST_bus);
    end
    cnt0 = m_cnt;
    drive(1'b1, 1'b1, mk_bus(1'b0, 7, 32'h0ADD_0007), 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (ID_allowin !== 1'b0) begin
      errors++; $display("FAIL ld_id_allowin: got %b expected 0", ID_allowin);
    end
    tick();
    checks++;
    if (EXE_valid !== 1'b0 || stall_cnt !== 32'(cnt0 + 1)) begin
      errors++; $display("FAIL ld_bubble: got valid=%b cnt=%0d expected valid=0 cnt=%0d", EXE_valid, stall_cnt, cnt0 + 1);
    end
    // Stall released: dependent instruction now moves into EXE
    drive(1'b1, 1'b1, mk_bus(1'b0, 7, 32'h0ADD_0007), 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    checks++;
    if (EXE_valid !== 1'b1 || EXE_bus !== m_bus) begin
      errors++; $display("FAIL ld_release: got valid=%b bus=%h expected valid=1 bus=%h", EXE_valid, EXE_bus, m_bus);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    held = EXE_bus;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, mk_bus(1'b0, 10 + i, 32'hBEEF_0000 + i), 1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (EXE_allowin !== 1'b0 || ID_allowin !== 1'b0) begin
        errors++; $display("FAIL bp_allowin_%0d: got exe=%b id=%b expected 0 0", i, EXE_allowin, ID_allowin);
      end
      tick();
      checks++;
      if (EXE_bus !== held || EXE_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold_%0d: got valid=%b bus=%h expected valid=1 bus=%h", i, EXE_valid, EXE_bus, held);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0]  c0;
    logic [W-1:0] held;
    c0 = stall_cnt;
    drive(1'b1, 1'b1, mk_bus(1'b1, 4, 32'hF1F1_0004), 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (ID_allowin !== 1'b1) begin
      errors++; $display("FAIL flush_id_allowin: got %b expected 1", ID_allowin);
    end
    tick();
    checks++;
    if (EXE_valid !== 1'b0 || stall_cnt !== c0) begin
      errors++; $display("FAIL flush_kill: got valid=%b cnt=%0d expected valid=0 cnt=%0d", EXE_valid, stall_cnt, c0);
    end
    // Flush while EXE is blocked must not disturb EXE contents
    drive(1'b1, 1'b1, mk_bus(1'b0, 21, 32'h5A5A_0021), 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    held = EXE_bus;
    drive(1'b1, 1'b1, mk_bus(1'b0, 22, 32'h5A5A_0022), 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (EXE_valid !== 1'b1 || EXE_bus !== held) begin
      errors++; $display("FAIL flush_blocked: got valid=%b bus=%h expected valid=1 bus=%h", EXE_valid, EXE_bus, held);
    end
  endtask

  task automatic test_saturation();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 1'b1, mk_bus(1'b0, 1, 32'h0000_5A7A), 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      checks++;
      if (stall_cnt4 !== ((i > 15) ? 4'hF : 4'(i)) || stall_cnt !== 32'(i)) begin
        errors++; $display("FAIL sat_%0d: got cnt4=%h cnt32=%0d expected cnt4=%h cnt32=%0d",
                           i, stall_cnt4, stall_cnt, (i > 15) ? 4'hF : 4'(i), i);
      end
    end
    checks++;
    if (stall_cnt4 !== 4'hF) begin
      errors++; $display("FAIL sat_final: got %h expected F", stall_cnt4);
    end
    // Reset asserted mid-stall clears valid and counter
    drive(1'b0, 1'b1, mk_bus(1'b0, 1, 32'h0000_5A7A), 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    checks++;
    if (EXE_valid !== 1'b0 || stall_cnt !== 32'd0 || stall_cnt4 !== 4'd0) begin
      errors++; $display("FAIL reset_mid_stall: got valid=%b cnt=%0d cnt4=%0d expected 0 0 0", EXE_valid, stall_cnt, stall_cnt4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99) >= 2), ($urandom_range(99) < 75),
            W'({$urandom(), $urandom()}), ($urandom_range(99) < 75),
            ($urandom_range(99) < 15), ($urandom_range(99) < 80), ($urandom_range(99) < 75));
      checks++;
      if ({ID_allowin, EXE_allowin, EXE_to_MEM_valid} !== {e_id_allowin(), e_exe_allowin(), m_valid && EXE_ready_go}) begin
        errors++;
        $display("FAIL rnd_comb_%0d: got id/exe/mem=%b%b%b expected %b%b%b", i, ID_allowin, EXE_allowin,
                 EXE_to_MEM_valid, e_id_allowin(), e_exe_allowin(), m_valid && EXE_ready_go);
      end
      tick();
      checks++;
      if (EXE_valid !== m_valid || EXE_bus !== m_bus || EXE_to_ST_bus !== e_to_st()) begin
        errors++;
        $display("FAIL rnd_reg_%0d: got valid=%b bus=%h st=%h expected valid=%b bus=%h st=%h",
                 i, EXE_valid, EXE_bus, EXE_to_ST_bus, m_valid, m_bus, e_to_st());
      end
      checks++;
      if (stall_cnt !== e_cnt32() || stall_cnt4 !== e_cnt4()) begin
        errors++;
        $display("FAIL rnd_cnt_%0d: got cnt=%0d cnt4=%0d expected cnt=%0d cnt4=%0d",
                 i, stall_cnt, stall_cnt4, e_cnt32(), e_cnt4());
      end
    end
  endtask

  initial begin
    m_valid = 1'b0; m_bus = '0; m_cnt = 0;
    test_reset();
    test_flow();
    test_load_use();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
